// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - camera sensor emulator: VSYNC/HREF/DATA timing with built-in test patterns.
// Optional frame checksum enabled by defining CAM_GEN_CHECKSUM_EN.
module cam_stream_gen #(
    parameter int HRES        = 640,
    parameter int VRES        = 480,
    parameter int DATA_W      = 8,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10,
    parameter int HBLANK      = 144,
    parameter int PCLK_DIV    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              fmt_i,
    input  logic [1:0]        pattern_i,
    input  logic [15:0]       const_pix_i,
    input  logic [7:0]        n_frames_i,
    output logic              cam_pclk_o,
    output logic              cam_vsync_o,
    output logic              cam_href_o,
    output logic [DATA_W-1:0] cam_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_cnt_o,
    output logic [31:0]       checksum_o,
    output logic              checksum_vld_o
);
    localparam int DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int BPL_MAX = (DATA_W == 8) ? 2 * HRES : HRES;
    localparam int CNT_W   = $clog2(BPL_MAX + HBLANK + 1);
    localparam int ROW_W   = $clog2(VRES + 1);
    localparam int COL_W   = $clog2(HRES + 1);
    localparam int BARW    = HRES / 8;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP} state_t;

    localparam state_t POST_VSYNC = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
    localparam state_t FIRST      = (VSYNC_LINES > 0) ? S_VSYNC : POST_VSYNC;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lcnt_q, lcnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d, barc_q, barc_d;
    logic [2:0]        bar_q, bar_d;
    logic              bsel_q, bsel_d;
    logic [15:0]       pix_q, pix_d;
    logic              fmt_q, fmt_d;
    logic [1:0]        pat_q, pat_d;
    logic [15:0]       cpix_q, cpix_d;
    logic [7:0]        nf_q, nf_d, run_q, run_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              done_q, done_d;

    logic              tick, two_byte, start, line_end, frame_end;
    logic [CNT_W-1:0]  line_m1, bpl_m1;
    logic [15:0]       phase_last;
    logic [15:0]       pix_val;
    logic [DATA_W-1:0] beat_w;

    assign tick     = (div_q == DIV_W'(PCLK_DIV - 1));
    assign two_byte = (DATA_W == 8) && fmt_q;
    assign line_m1  = two_byte ? CNT_W'(BPL_MAX + HBLANK - 1) : CNT_W'(HRES + HBLANK - 1);
    assign bpl_m1   = two_byte ? CNT_W'(BPL_MAX - 1) : CNT_W'(HRES - 1);

    always_comb begin
        phase_last = 16'(VFP_LINES - 1);
        if (state_q == S_VSYNC) phase_last = 16'(VSYNC_LINES - 1);
        else if (state_q == S_VBP) phase_last = 16'(VBP_LINES - 1);
    end

    always_comb begin
        state_d = state_q;  cnt_d  = cnt_q;   lcnt_d = lcnt_q;  row_d  = row_q;
        col_d   = col_q;    barc_d = barc_q;  bar_d  = bar_q;   bsel_d = bsel_q;
        pix_d   = pix_q;    fmt_d  = fmt_q;   pat_d  = pat_q;   cpix_d = cpix_q;
        nf_d    = nf_q;     run_d  = run_q;   fcnt_d = fcnt_q;  done_d = 1'b0;
        start = 1'b0; line_end = 1'b0; frame_end = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: start = en_i;
                S_VSYNC, S_VBP, S_VFP: begin
                    if (cnt_q == line_m1) begin
                        cnt_d = '0;
                        if (lcnt_q == phase_last) begin
                            lcnt_d = '0;
                            if (state_q == S_VSYNC)    state_d = POST_VSYNC;
                            else if (state_q == S_VBP) state_d = S_ACTIVE;
                            else                       frame_end = 1'b1;
                        end else begin
                            lcnt_d = lcnt_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    // The pixel counter also steps on the last beat so the next line continues from it.
                    if (two_byte && !bsel_q) begin
                        bsel_d = 1'b1;
                    end else begin
                        bsel_d = 1'b0;
                        col_d  = col_q + 1'b1;
                        pix_d  = pix_q + 16'd1;
                        if (barc_q == COL_W'(BARW - 1) && bar_q != 3'd7) begin
                            barc_d = '0;
                            bar_d  = bar_q + 3'd1;
                        end else begin
                            barc_d = barc_q + 1'b1;
                        end
                    end
                    if (cnt_q == bpl_m1) begin
                        cnt_d = '0;
                        if (HBLANK > 0) state_d = S_HBLANK;
                        else            line_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == CNT_W'(HBLANK - 1)) begin
                        cnt_d    = '0;
                        line_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (line_end) begin
            col_d = '0; barc_d = '0; bar_d = '0; bsel_d = 1'b0;
            if (row_q == ROW_W'(VRES - 1)) begin
                row_d = '0;
                if (VFP_LINES > 0) state_d = S_VFP;
                else               frame_end = 1'b1;
            end else begin
                row_d   = row_q + 1'b1;
                state_d = S_ACTIVE;
            end
        end
        if (frame_end) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
            run_d  = run_q + 8'd1;
            if (en_i && (nf_q == 8'd0 || ({1'b0, run_q} + 9'd1) < {1'b0, nf_q})) start = 1'b1;
            else                                                               state_d = S_IDLE;
        end
        if (start) begin
            state_d = FIRST;
            cnt_d = '0; lcnt_d = '0; row_d = '0; col_d = '0; barc_d = '0; bar_d = '0;
            bsel_d = 1'b0; pix_d = '0;
            fmt_d = fmt_i; pat_d = pattern_i; cpix_d = const_pix_i; nf_d = n_frames_i;
            if (state_q == S_IDLE) run_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE; div_q <= '0;  cnt_q <= '0;  lcnt_q <= '0; row_q <= '0;
            col_q <= '0;  barc_q <= '0; bar_q <= '0; bsel_q <= 1'b0; pix_q <= '0;
            fmt_q <= 1'b0; pat_q <= '0; cpix_q <= '0; nf_q <= '0; run_q <= '0;
            fcnt_q <= '0; done_q <= 1'b0;
        end else begin
            div_q   <= tick ? '0 : div_q + 1'b1;
            state_q <= state_d; cnt_q <= cnt_d;   lcnt_q <= lcnt_d; row_q <= row_d;
            col_q   <= col_d;   barc_q <= barc_d; bar_q <= bar_d;   bsel_q <= bsel_d;
            pix_q   <= pix_d;   fmt_q <= fmt_d;   pat_q <= pat_d;   cpix_q <= cpix_d;
            nf_q    <= nf_d;    run_q <= run_d;   fcnt_q <= fcnt_d; done_q <= done_d;
        end
    end

    always_comb begin
        case (pat_q)
            2'd0: begin
                case (bar_q)
                    3'd0: pix_val = 16'hFFFF;
                    3'd1: pix_val = 16'hFFE0;
                    3'd2: pix_val = 16'h07FF;
                    3'd3: pix_val = 16'h07E0;
                    3'd4: pix_val = 16'hF81F;
                    3'd5: pix_val = 16'hF800;
                    3'd6: pix_val = 16'h001F;
                    default: pix_val = 16'h0000;
                endcase
            end
            2'd1:    pix_val = pix_q;
            2'd2:    pix_val = 16'(col_q);
            default: pix_val = cpix_q;
        endcase
    end

    generate
        if (DATA_W == 8) begin : g_byte
            assign beat_w = (two_byte && bsel_q) ? pix_val[7:0] : pix_val[15:8];
        end else begin : g_word
            assign beat_w = fmt_q ? pix_val : {8'h00, pix_val[15:8]};
        end
    endgenerate

    assign cam_pclk_o   = tick && !rst_i;
    assign cam_vsync_o  = (state_q == S_VSYNC);
    assign cam_href_o   = (state_q == S_ACTIVE);
    assign cam_data_o   = cam_href_o ? beat_w : '0;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;
    assign frame_cnt_o  = fcnt_q;

`ifdef CAM_GEN_CHECKSUM_EN
    logic [31:0] acc_q, ck_q, acc_nxt;
    logic        ckv_q;

    // A frame can end on an active beat when VFP and HBLANK are both zero, so fold that beat in first.
    assign acc_nxt = acc_q + (cam_href_o ? {{(32 - DATA_W){1'b0}}, beat_w} : 32'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0; ck_q <= '0; ckv_q <= 1'b0;
        end else begin
            ckv_q <= tick && frame_end;
            if (tick) begin
                acc_q <= start ? 32'd0 : acc_nxt;
                if (frame_end) ck_q <= acc_nxt;
            end
        end
    end

    assign checksum_o     = ck_q;
    assign checksum_vld_o = ckv_q;
`else
    assign checksum_o     = 32'd0;
    assign checksum_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - scoreboard bench for cam_stream_gen (HRES=8, VRES=2, PCLK_DIV=3).
module tb_cam_stream_gen;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1, en_i = 1'b0, fmt_i = 1'b0;
    logic [1:0]  pattern_i = 2'd0;
    logic [15:0] const_pix_i = 16'd0;
    logic [7:0]  n_frames_i = 8'd0;
    logic        cam_pclk_o, cam_vsync_o, cam_href_o, busy_o, frame_done_o, checksum_vld_o;
    logic [7:0]  cam_data_o;
    logic [15:0] frame_cnt_o;
    logic [31:0] checksum_o;

`ifdef CAM_GEN_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    cam_stream_gen #(
        .HRES(8), .VRES(2), .DATA_W(8), .VSYNC_LINES(1), .VBP_LINES(1),
        .VFP_LINES(1), .HBLANK(4), .PCLK_DIV(3)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .fmt_i(fmt_i), .pattern_i(pattern_i),
        .const_pix_i(const_pix_i), .n_frames_i(n_frames_i), .cam_pclk_o(cam_pclk_o),
        .cam_vsync_o(cam_vsync_o), .cam_href_o(cam_href_o), .cam_data_o(cam_data_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
        .checksum_o(checksum_o), .checksum_vld_o(checksum_vld_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] sum;
        int          nbytes;
    } frame_t;

    logic [7:0] byte_q[$];
    frame_t     frame_q[$];
    int checks = 0, errors = 0;
    int exp_frames = 0;
    int gap = 0, fbytes = 0, mon_beats = 0, done_seen = 0, busy_clks = 0, vsync_clks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int pat, input int col, input int line,
                                              input logic [15:0] cp);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (pat)
            0:       return bars[col];
            1:       return 16'(line * 8 + col);
            2:       return 16'(col);
            default: return cp;
        endcase
    endfunction

    task automatic push_frame(input bit fmt, input int pat, input logic [15:0] cp);
        frame_t f;
        logic [15:0] p;
        f.sum = 0;
        f.nbytes = 0;
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < 8; c++) begin
                p = model_pix(pat, c, ln, cp);
                byte_q.push_back(p[15:8]);
                f.sum += {24'd0, p[15:8]};
                f.nbytes++;
                if (fmt) begin
                    byte_q.push_back(p[7:0]);
                    f.sum += {24'd0, p[7:0]};
                    f.nbytes++;
                end
            end
        end
        exp_frames++;
        f.cnt = 16'(exp_frames);
        frame_q.push_back(f);
    endtask

    always @(negedge clk) begin
        logic [7:0] eb;
        frame_t f;
        if (rst_i) begin
            gap = 0;
            fbytes = 0;
        end else begin
            gap++;
            if (busy_o) busy_clks++;
            if (cam_vsync_o) vsync_clks++;
            if (cam_pclk_o) begin
                chk("pclk_period", gap, 3);
                gap = 0;
                if (cam_href_o) begin
                    if (byte_q.size() == 0) begin
                        chk("extra_beat", {24'd0, cam_data_o}, 32'hFFFF_FFFF);
                    end else begin
                        eb = byte_q.pop_front();
                        chk("pixel_byte", {24'd0, cam_data_o}, {24'd0, eb});
                    end
                    fbytes++;
                    mon_beats++;
                end else begin
                    chk("blank_data", {24'd0, cam_data_o}, 32'd0);
                end
            end
            if (frame_done_o) begin
                done_seen++;
                if (frame_q.size() == 0) begin
                    chk("extra_frame", {16'd0, frame_cnt_o}, 32'hFFFF_FFFF);
                end else begin
                    f = frame_q.pop_front();
                    chk("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, f.cnt});
                    chk("frame_beats", fbytes, f.nbytes);
                    chk("checksum", checksum_o, CK_EN ? f.sum : 32'd0);
                    chk("checksum_vld", {31'd0, checksum_vld_o}, {31'd0, CK_EN});
                end
                fbytes = 0;
            end else if (checksum_vld_o) begin
                chk("stray_checksum_vld", 32'd1, 32'd0);
            end
        end
    end

    task automatic wait_beats(input int base, input int n);
        int t = 0;
        while (mon_beats - base < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) chk("beat_timeout", mon_beats - base, n);
    endtask

    task automatic run_frames(input int d0, input int n);
        int t = 0;
        while (done_seen - d0 < n && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) chk("frame_timeout", done_seen - d0, n);
        en_i = 1'b0;
        chk("busy_after_run", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_sync_href_pclk"}, {29'd0, cam_vsync_o, cam_href_o, cam_pclk_o}, 32'd0);
        chk({tag, "_data"}, {24'd0, cam_data_o}, 32'd0);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt_o}, 32'd0);
        chk({tag, "_done_cksum"}, {31'd0, frame_done_o | checksum_vld_o}, 32'd0);
        chk({tag, "_checksum"}, checksum_o, 32'd0);
    endtask

    initial begin
        int b0, v0, d0, m0;
        repeat (5) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_i = 1'b0;

        // RGB565 counter pattern, one frame: 100 ticks of 3 clks each.
        fmt_i = 1'b1; pattern_i = 2'd1; n_frames_i = 8'd1;
        push_frame(1'b1, 1, 16'h0);
        b0 = busy_clks; v0 = vsync_clks; d0 = done_seen;
        en_i = 1'b1;
        run_frames(d0, 1);
        chk("t1_busy_clks", busy_clks - b0, 300);
        chk("t1_vsync_clks", vsync_clks - v0, 60);
        chk("t1_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // RAW8 colour bars: 12-tick lines.
        repeat (4) @(posedge clk); #1;
        fmt_i = 1'b0; pattern_i = 2'd0;
        push_frame(1'b0, 0, 16'h0);
        b0 = busy_clks; v0 = vsync_clks; d0 = done_seen;
        en_i = 1'b1;
        run_frames(d0, 1);
        chk("t2_busy_clks", busy_clks - b0, 180);
        chk("t2_vsync_clks", vsync_clks - v0, 36);

        // Unlimited run, en dropped during line 1: the frame still completes.
        repeat (4) @(posedge clk); #1;
        fmt_i = 1'b1; pattern_i = 2'd3; const_pix_i = 16'hA55A; n_frames_i = 8'd0;
        push_frame(1'b1, 3, 16'hA55A);
        d0 = done_seen; m0 = mon_beats;
        en_i = 1'b1;
        wait_beats(m0, 20);
        en_i = 1'b0;
        run_frames(d0, 1);
        repeat (120) @(posedge clk); #1;
        chk("t3_one_frame", done_seen - d0, 1);
        chk("t3_frame_cnt", {16'd0, frame_cnt_o}, 32'd3);

        // Reset in the middle of an active line, then a full frame after restart.
        fmt_i = 1'b1; pattern_i = 2'd2; n_frames_i = 8'd1;
        push_frame(1'b1, 2, 16'h0);
        m0 = mon_beats;
        en_i = 1'b1;
        wait_beats(m0, 5);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        byte_q.delete();
        frame_q.delete();
        exp_frames = 0;
        push_frame(1'b1, 2, 16'h0);
        d0 = done_seen;
        rst_i = 1'b0;
        run_frames(d0, 1);
        chk("t4_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // Pattern changed mid-frame only shows from the next frame.
        repeat (4) @(posedge clk); #1;
        fmt_i = 1'b0; pattern_i = 2'd3; const_pix_i = 16'h1200; n_frames_i = 8'd0;
        push_frame(1'b0, 3, 16'h1200);
        push_frame(1'b0, 2, 16'h0);
        d0 = done_seen; m0 = mon_beats;
        en_i = 1'b1;
        wait_beats(m0, 4);
        pattern_i = 2'd2;
        wait_beats(m0, 20);
        en_i = 1'b0;
        run_frames(d0, 2);
        chk("t5_frame_cnt", {16'd0, frame_cnt_o}, 32'd3);

        repeat (10) @(posedge clk); #1;
        chk("bytes_left", byte_q.size(), 0);
        chk("frames_left", frame_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
